// File: rtl/sram_bus_arbiter.sv
// Two-master (fetch / load-store) arbiter onto a single SRAM-style port.
// One transaction outstanding at a time; data has priority with an anti-starvation limit for fetch.
module sram_bus_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;

  state_t        state;
  logic          lock_data;   // grant held while the slave stalls address acceptance
  logic          owner_data;
  logic [CW-1:0] starve_cnt;

  logic sel_data, presenting, accept, in_wait, starved;

  always_comb begin
    starved    = inst_req && (starve_cnt == CW'(STARVE_MAX));
    sel_data   = (state == ADDR) ? lock_data : (data_req && !starved);
    presenting = !rst && ((state == ADDR) || (state == IDLE && (inst_req || data_req)));
    accept     = presenting && bus_addr_ok;
    in_wait    = !rst && (state == WAIT);

    bus_req      = presenting;
    bus_wr       = presenting && sel_data && data_wr;
    bus_wstrb    = (presenting && sel_data) ? data_wstrb : 4'h0;
    bus_wdata    = (presenting && sel_data) ? data_wdata : 32'h0;
    bus_addr     = !presenting ? 32'h0 : (sel_data ? data_addr : inst_addr);
    inst_addr_ok = accept && !sel_data;
    data_addr_ok = accept && sel_data;

    // Responses only reach the recorded owner, and only while a transaction is outstanding.
    inst_data_ok = in_wait && !owner_data && bus_data_ok;
    data_data_ok = in_wait && owner_data && bus_data_ok;
    inst_rdata   = (in_wait && !owner_data) ? bus_rdata : 32'h0;
    data_rdata   = (in_wait && owner_data) ? bus_rdata : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lock_data  <= 1'b0;
      owner_data <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE, ADDR: begin
          if (presenting) begin
            if (bus_addr_ok) begin
              state      <= WAIT;
              owner_data <= sel_data;
            end else begin
              state     <= ADDR;
              lock_data <= sel_data;
            end
          end
        end
        WAIT: if (bus_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (!inst_req)
        starve_cnt <= '0;
      else if (accept && !sel_data)
        starve_cnt <= '0;
      else if (accept && sel_data && starve_cnt != CW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios plus random traffic checked against a transaction-level model.
module tb_sram_bus_arbiter;
  localparam int SM = 4;

  logic        clk, rst;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  sram_bus_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference: "busy" = a request accepted and not yet answered,
  // "hold" = a master picked but the slave has not taken its address yet.
  bit m_busy, m_hold, m_hold_data, m_owner_data;
  int m_starve;
  int who;  // -1 none, 0 inst, 1 data

  task automatic pick();
    if (rst || m_busy) who = -1;
    else if (m_hold) who = m_hold_data ? 1 : 0;
    else if (data_req && !(inst_req && m_starve == SM)) who = 1;
    else if (inst_req) who = 0;
    else who = -1;
  endtask

  task automatic cmp_all(input string tag);
    bit rsp_i, rsp_d;
    pick();
    rsp_i = !rst && m_busy && !m_owner_data;
    rsp_d = !rst && m_busy && m_owner_data;
    chk({tag, ".bus_req"},   bus_req,      (who >= 0) ? 32'd1 : 32'd0);
    chk({tag, ".bus_wr"},    bus_wr,       (who == 1) ? 32'(data_wr) : 32'd0);
    chk({tag, ".bus_wstrb"}, bus_wstrb,    (who == 1) ? 32'(data_wstrb) : 32'd0);
    chk({tag, ".bus_wdata"}, bus_wdata,    (who == 1) ? data_wdata : 32'd0);
    chk({tag, ".bus_addr"},  bus_addr,     (who == 1) ? data_addr : (who == 0) ? inst_addr : 32'd0);
    chk({tag, ".i_aok"},     inst_addr_ok, (who == 0) ? 32'(bus_addr_ok) : 32'd0);
    chk({tag, ".d_aok"},     data_addr_ok, (who == 1) ? 32'(bus_addr_ok) : 32'd0);
    chk({tag, ".i_dok"},     inst_data_ok, rsp_i ? 32'(bus_data_ok) : 32'd0);
    chk({tag, ".d_dok"},     data_data_ok, rsp_d ? 32'(bus_data_ok) : 32'd0);
    chk({tag, ".i_rdata"},   inst_rdata,   rsp_i ? bus_rdata : 32'd0);
    chk({tag, ".d_rdata"},   data_rdata,   rsp_d ? bus_rdata : 32'd0);
  endtask

  task automatic advance();
    bit acc;
    pick();
    acc = (who >= 0) && bus_addr_ok;
    if (rst) begin
      m_busy = 0; m_hold = 0; m_owner_data = 0; m_starve = 0;
    end else begin
      if (!inst_req) m_starve = 0;
      else if (acc && who == 0) m_starve = 0;
      else if (acc && who == 1 && m_starve < SM) m_starve++;
      if (m_busy) begin
        if (bus_data_ok) m_busy = 0;
      end else if (who >= 0) begin
        if (bus_addr_ok) begin
          m_busy = 1; m_hold = 0; m_owner_data = (who == 1);
        end else begin
          m_hold = 1; m_hold_data = (who == 1);
        end
      end
    end
  endtask

  task automatic settle(input string tag);
    @(negedge clk);
    cmp_all(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic step(input string tag);
    settle(tag);
    tick();
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_wstrb = 0;
    data_addr = 0; data_wdata = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
  endtask

  bit grants[$];
  bit exp_g[6] = '{1, 1, 1, 1, 0, 1};

  initial begin
    m_busy = 0; m_hold = 0; m_hold_data = 0; m_owner_data = 0; m_starve = 0;
    rst = 1; idle_inputs();
    #1;
    step("reset");
    step("reset2");
    rst = 0;

    // Single fetch, data returned two cycles after acceptance.
    inst_req = 1; inst_addr = 32'hBFC00000; bus_addr_ok = 1;
    settle("fetch_a");
    chk("fetch.bus_addr", bus_addr, 32'hBFC00000);
    chk("fetch.aok", inst_addr_ok, 1);
    tick();
    inst_req = 0; bus_addr_ok = 0;
    step("fetch_w");
    bus_data_ok = 1; bus_rdata = 32'h3C08BFC0;
    settle("fetch_d");
    chk("fetch.dok", inst_data_ok, 1);
    chk("fetch.rdata", inst_rdata, 32'h3C08BFC0);
    tick();
    idle_inputs();

    // Simultaneous requests: store wins first, fetch follows its completion.
    inst_req = 1; inst_addr = 32'hBFC00004;
    data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_addr = 32'h80000010; data_wdata = 32'h12345678;
    bus_addr_ok = 1;
    settle("both_a");
    chk("both.d_aok", data_addr_ok, 1);
    chk("both.bus_wr", bus_wr, 1);
    chk("both.i_aok", inst_addr_ok, 0);
    tick();
    data_req = 0; data_wr = 0; bus_addr_ok = 0; bus_data_ok = 1;
    settle("both_w");
    chk("both.d_dok", data_data_ok, 1);
    tick();
    bus_data_ok = 0; bus_addr_ok = 1;
    settle("both_i");
    chk("both.i_aok2", inst_addr_ok, 1);
    chk("both.i_addr", bus_addr, 32'hBFC00004);
    tick();
    idle_inputs(); bus_data_ok = 1;
    step("both_end");
    idle_inputs();

    // Starvation limit: 4 data grants, then one fetch, then data again.
    step("starve_clr");
    inst_req = 1; inst_addr = 32'hBFC00100; data_req = 1; data_addr = 32'h80000100;
    bus_addr_ok = 1; bus_data_ok = 1;
    for (int c = 0; c < 12; c++) begin
      settle("starve");
      if (inst_addr_ok) grants.push_back(0);
      if (data_addr_ok) grants.push_back(1);
      tick();
    end
    chk("starve.count", grants.size(), 6);
    for (int g = 0; g < 6 && g < grants.size(); g++) chk($sformatf("starve.g%0d", g), grants[g], exp_g[g]);
    idle_inputs(); bus_data_ok = 1;
    step("starve_end");
    idle_inputs();
    step("starve_end2");

    // Locked fetch grant while the slave stalls and data_req rises.
    inst_req = 1; inst_addr = 32'hBFC00200;
    settle("lock0");
    chk("lock0.addr", bus_addr, 32'hBFC00200);
    tick();
    data_req = 1; data_addr = 32'h80000200;
    for (int c = 1; c < 4; c++) begin
      bus_addr_ok = (c == 3);
      settle("lock");
      chk($sformatf("lock%0d.addr", c), bus_addr, 32'hBFC00200);
      chk($sformatf("lock%0d.d_aok", c), data_addr_ok, 0);
      if (c == 3) chk("lock3.i_aok", inst_addr_ok, 1);
      tick();
    end
    idle_inputs(); bus_data_ok = 1;
    step("lock_end");
    idle_inputs();

    // Reset while waiting; a late response must be dropped.
    inst_req = 1; inst_addr = 32'hBFC00300; bus_addr_ok = 1;
    step("rst_a");
    idle_inputs(); rst = 1;
    settle("rst_in");
    chk("rst.bus_req", bus_req, 0);
    tick();
    rst = 0; bus_data_ok = 1; bus_rdata = 32'hDEADBEEF;
    settle("rst_late");
    chk("rst.i_dok", inst_data_ok, 0);
    chk("rst.d_dok", data_data_ok, 0);
    tick();
    idle_inputs(); inst_req = 1; inst_addr = 32'hBFC00304; bus_addr_ok = 1;
    settle("rst_idle");
    chk("rst.idle_aok", inst_addr_ok, 1);
    tick();
    idle_inputs(); bus_data_ok = 1;
    step("rst_end");

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(63) == 0);
      inst_req    = ($urandom_range(3) != 0);
      inst_addr   = $urandom;
      data_req    = ($urandom_range(2) != 0);
      data_wr     = $urandom_range(1);
      data_wstrb  = 4'($urandom);
      data_addr   = $urandom;
      data_wdata  = $urandom;
      bus_addr_ok = ($urandom_range(4) > 1);
      bus_data_ok = ($urandom_range(1) == 1);
      bus_rdata   = $urandom;
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
